// File: rtl/vip_frame_gate_ctrl_if.sv
// rtl/vip_frame_gate_ctrl_if.sv - CMOS frame timing bus (vsync/href/clken + 16-bit 4:2:2 word)
//
// Ports (modports):
//   master : drives vsync, href, clken, ycbcr
//   slave  : samples vsync, href, clken, ycbcr
interface vip_frame_gate_ctrl_if;
  logic        vsync;
  logic        href;
  logic        clken;
  logic [15:0] ycbcr;

  modport master (output vsync, href, clken, ycbcr);
  modport slave  (input  vsync, href, clken, ycbcr);
endinterface

// File: rtl/vip_frame_gate_ctrl.sv
// rtl/vip_frame_gate_ctrl.sv - frame gate/decimator in front of the 4:2:2 -> 4:4:4 converter
//
// Ports:
//   clk, rst_n        pixel clock, asynchronous active-low reset
//   cfg_enable        run request (stop takes effect only at a frame boundary)
//   cfg_skip          frames dropped after each passed frame
//   cfg_h_active      expected clken beats per line
//   cfg_v_active      expected lines per frame
//   per_frame         incoming CMOS timing + data (slave)
//   gate_frame        gated timing + data, 1 clk latency (master)
//   frame_done        pulse when a passed frame ends
//   err_line          pulse, line of a passed frame had the wrong beat count
//   err_frame         pulse with frame_done, passed frame had the wrong line count
//   busy              controller is not idle
module vip_frame_gate_ctrl #(
  parameter int CNT_W = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_enable,
  input  logic [3:0]            cfg_skip,
  input  logic [CNT_W-1:0]      cfg_h_active,
  input  logic [CNT_W-1:0]      cfg_v_active,
  vip_frame_gate_ctrl_if.slave  per_frame,
  vip_frame_gate_ctrl_if.master gate_frame,
  output logic                  frame_done,
  output logic                  err_line,
  output logic                  err_frame,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, PASS, SKIP} state_t;

  state_t             state_q, state_d, mode;
  logic               vs_dly_q, href_dly_q;
  logic [3:0]         skip_cnt_q, skip_cnt_d;
  logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0]   line_cnt_q, line_cnt_d;
  logic [CNT_W-1:0]   h_lat_q, h_lat_d;
  logic [CNT_W-1:0]   v_lat_q, v_lat_d;
  logic               gate_vs_q, gate_vs_d;
  logic               gate_href_q, gate_href_d;
  logic               gate_clken_q, gate_clken_d;
  logic [15:0]        gate_data_q, gate_data_d;
  logic               frame_done_q, frame_done_d;
  logic               err_line_q, err_line_d;
  logic               err_frame_q, err_frame_d;
  logic               sof, eol, start_pass;

  assign sof = per_frame.vsync & ~vs_dly_q;
  assign eol = href_dly_q & ~per_frame.href;

  always_comb begin
    state_d      = state_q;
    skip_cnt_d   = skip_cnt_q;
    pix_cnt_d    = pix_cnt_q;
    line_cnt_d   = line_cnt_q;
    h_lat_d      = h_lat_q;
    v_lat_d      = v_lat_q;
    frame_done_d = 1'b0;
    err_line_d   = 1'b0;
    err_frame_d  = 1'b0;
    start_pass   = 1'b0;

    // Line measurement runs only inside a passed frame.
    if (state_q == PASS) begin
      if (eol) begin
        err_line_d = (pix_cnt_q != h_lat_q);
        pix_cnt_d  = '0;
        if (line_cnt_q != '1) line_cnt_d = line_cnt_q + CNT_W'(1);
      end else if (per_frame.href && per_frame.clken && pix_cnt_q != '1) begin
        pix_cnt_d = pix_cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (cfg_enable) state_d = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (!cfg_enable) state_d = IDLE;
        else if (sof)    start_pass = 1'b1;
      end
      default: begin
        if (sof) begin
          if (state_q == PASS) begin
            // line_cnt_d already includes an EOL landing on this same cycle.
            frame_done_d = 1'b1;
            err_frame_d  = (line_cnt_d != v_lat_q);
          end
          if (!cfg_enable) begin
            state_d = IDLE;
          end else if (skip_cnt_q == 4'd0) begin
            start_pass = 1'b1;
          end else begin
            state_d    = SKIP;
            skip_cnt_d = skip_cnt_q - 4'd1;
          end
        end
      end
    endcase

    if (start_pass) begin
      state_d    = PASS;
      skip_cnt_d = cfg_skip;
      h_lat_d    = cfg_h_active;
      v_lat_d    = cfg_v_active;
    end

    if (sof) begin
      pix_cnt_d  = '0;
      line_cnt_d = '0;
    end

    // The SOF cycle already belongs to the frame being started.
    mode = sof ? state_d : state_q;

    gate_vs_d    = ((mode == PASS) || (mode == SKIP)) && per_frame.vsync;
    gate_href_d  = (mode == PASS) && per_frame.href;
    gate_clken_d = (mode == PASS) && per_frame.clken;
    gate_data_d  = (mode == PASS) ? per_frame.ycbcr : 16'h0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vs_dly_q     <= 1'b0;
      href_dly_q   <= 1'b0;
      skip_cnt_q   <= '0;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      h_lat_q      <= '0;
      v_lat_q      <= '0;
      gate_vs_q    <= 1'b0;
      gate_href_q  <= 1'b0;
      gate_clken_q <= 1'b0;
      gate_data_q  <= '0;
      frame_done_q <= 1'b0;
      err_line_q   <= 1'b0;
      err_frame_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_dly_q     <= per_frame.vsync;
      href_dly_q   <= per_frame.href;
      skip_cnt_q   <= skip_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      h_lat_q      <= h_lat_d;
      v_lat_q      <= v_lat_d;
      gate_vs_q    <= gate_vs_d;
      gate_href_q  <= gate_href_d;
      gate_clken_q <= gate_clken_d;
      gate_data_q  <= gate_data_d;
      frame_done_q <= frame_done_d;
      err_line_q   <= err_line_d;
      err_frame_q  <= err_frame_d;
    end
  end

  assign gate_frame.vsync = gate_vs_q;
  assign gate_frame.href  = gate_href_q;
  assign gate_frame.clken = gate_clken_q;
  assign gate_frame.ycbcr = gate_data_q;
  assign frame_done       = frame_done_q;
  assign err_line         = err_line_q;
  assign err_frame        = err_frame_q;
  assign busy             = (state_q != IDLE);

endmodule
